// File: rtl/refresh_scheduler_pkg.sv
// Shared types and constants for the DRAM refresh scheduler.
package refresh_scheduler_pkg;

    // Tick generator operating state
    typedef enum logic {
        DISABLED = 1'b0,
        COUNT    = 1'b1
    } ref_state_e;

    // JEDEC ceiling on postponed refreshes
    localparam int JEDEC_MAX_POSTPONE = 8;

endpackage

// File: rtl/refresh_tick_gen.sv
// tREFI interval timer: loadable down-counter that emits a one-cycle tick
// each time the interval expires. A new period is picked up only on reload.
module refresh_tick_gen
    import refresh_scheduler_pkg::*;
#(
    parameter int C_WIDTH = 16
) (
    input  logic               clk,
    input  logic               arstn,
    input  logic               enable,
    input  logic [C_WIDTH-1:0] period,
    output logic               tick
);

    localparam logic [C_WIDTH-1:0] ONE = C_WIDTH'(1);

    ref_state_e         state_q, state_d;
    logic [C_WIDTH-1:0] cnt_q, cnt_d;
    logic               run;

    // A zero period means no ticks, treat it like being disabled
    assign run = enable && (period != '0);

    // State and counter registers
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q <= DISABLED;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, counter reload and tick generation
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tick    = 1'b0;
        unique case (state_q)
            DISABLED: begin
                cnt_d = '0;
                if (run) begin
                    state_d = COUNT;
                    cnt_d   = period - ONE;
                end
            end
            COUNT: begin
                if (!run) begin
                    state_d = DISABLED;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    tick  = 1'b1;
                    cnt_d = period - ONE;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            default: begin
                state_d = DISABLED;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: rtl/refresh_scheduler.sv
// Refresh scheduler: turns tREFI ticks into a backlog of owed REF commands,
// presents it to main_control as a level request with an urgency flag, and
// retires one entry per ref_ack pulse.
// Optional pull-in (issuing refreshes ahead of schedule while idle) is built
// only when REFRESH_PULLIN_EN is defined.
module refresh_scheduler
    import refresh_scheduler_pkg::*;
#(
    parameter int C_TREFI_WIDTH   = 16,
    parameter int C_MAX_POSTPONE  = JEDEC_MAX_POSTPONE,
    parameter int C_URGENT_THRESH = 6,
    parameter int C_MAX_PULLIN    = 8
) (
    input  logic                     core_clk,
    input  logic                     core_arstn,
    input  logic                     enable,
    input  logic [C_TREFI_WIDTH-1:0] trefi_cycles,
    input  logic                     idle,
    input  logic                     ref_ack,
    output logic                     ref_req,
    output logic                     ref_urgent,
    output logic [3:0]               pending_cnt,
    output logic                     overflow_err,
    input  logic                     clear_err
);

    localparam logic [3:0] MAX_POST = 4'(C_MAX_POSTPONE);
    localparam logic [3:0] URG_TH   = 4'(C_URGENT_THRESH);

    logic       run, tick;
    logic [3:0] pending_q, pending_d;
    logic       ovf_set, err_d, req_d, urg_d;
    logic       ahead_zero;

    assign run = enable && (trefi_cycles != '0);

    refresh_tick_gen #(
        .C_WIDTH (C_TREFI_WIDTH)
    ) u_tick_gen (
        .clk    (core_clk),
        .arstn  (core_arstn),
        .enable (enable),
        .period (trefi_cycles),
        .tick   (tick)
    );

`ifdef REFRESH_PULLIN_EN
    localparam logic [3:0] MAX_PULL = 4'(C_MAX_PULLIN);

    logic [3:0] ahead_q, ahead_d;
    logic       offer_d;

    assign ahead_zero = (ahead_q == '0);

    // Refreshes done early: acks with nothing owed bank credit, ticks spend it
    always_comb begin
        ahead_d = ahead_q;
        if (!run) begin
            ahead_d = '0;
        end else if (tick && !ref_ack && !ahead_zero) begin
            ahead_d = ahead_q - 4'd1;
        end else if (ref_ack && !tick && pending_q == '0 && ahead_q < MAX_PULL) begin
            ahead_d = ahead_q + 4'd1;
        end
    end

    // Pull-in credit register
    always_ff @(posedge core_clk or negedge core_arstn) begin
        if (!core_arstn) ahead_q <= '0;
        else             ahead_q <= ahead_d;
    end

    // Offer an early refresh only while the controller is idle and nothing is owed
    assign offer_d = run && idle && (pending_d == '0) && (ahead_d < MAX_PULL);
    assign req_d   = (pending_d != '0) || offer_d;
`else
    logic unused_idle;

    assign unused_idle = idle;
    assign ahead_zero  = 1'b1;
    assign req_d       = (pending_d != '0);
`endif

    // Backlog update: tick adds, ack retires, both together cancel out
    always_comb begin
        pending_d = pending_q;
        ovf_set   = 1'b0;
        if (!run) begin
            pending_d = '0;
        end else if (tick && ref_ack) begin
            if (pending_q == '0 && ahead_zero) pending_d = 4'd1;
        end else if (tick) begin
            if (ahead_zero) begin
                if (pending_q < MAX_POST) pending_d = pending_q + 4'd1;
                else                      ovf_set   = 1'b1;
            end
        end else if (ref_ack) begin
            if (pending_q != '0) pending_d = pending_q - 4'd1;
        end
    end

    // A new overflow beats a same-cycle clear
    assign err_d = ovf_set ? 1'b1 : (clear_err ? 1'b0 : overflow_err);
    assign urg_d = (pending_d >= URG_TH);

    // Registered outputs
    always_ff @(posedge core_clk or negedge core_arstn) begin
        if (!core_arstn) begin
            pending_q    <= '0;
            ref_req      <= 1'b0;
            ref_urgent   <= 1'b0;
            overflow_err <= 1'b0;
        end else begin
            pending_q    <= pending_d;
            ref_req      <= req_d;
            ref_urgent   <= urg_d;
            overflow_err <= err_d;
        end
    end

    assign pending_cnt = pending_q;

endmodule

// File: tb/tb_refresh_scheduler.sv
// Self-checking bench for refresh_scheduler (default build, pull-in off).
// The reference model tracks absolute tick times and an integer backlog.
module tb_refresh_scheduler;

    logic        core_clk = 1'b0;
    logic        core_arstn = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] trefi_cycles = 16'd0;
    logic        idle = 1'b0;
    logic        ref_ack = 1'b0;
    logic        clear_err = 1'b0;
    logic        ref_req, ref_urgent, overflow_err;
    logic [3:0]  pending_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    int m_cyc = 0;      // index of the upcoming rising edge
    int m_next = 0;     // edge index at which the next tick is taken
    bit m_running = 0;
    int m_pend = 0;
    bit m_err = 0;

    refresh_scheduler dut (
        .core_clk     (core_clk),
        .core_arstn   (core_arstn),
        .enable       (enable),
        .trefi_cycles (trefi_cycles),
        .idle         (idle),
        .ref_ack      (ref_ack),
        .ref_req      (ref_req),
        .ref_urgent   (ref_urgent),
        .pending_cnt  (pending_cnt),
        .overflow_err (overflow_err),
        .clear_err    (clear_err)
    );

    always #5 core_clk = ~core_clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at edge %0d: got %0d, expected %0d", name, m_cyc, act, exp);
        end
    endtask

    // Advance one clock, update the model from the inputs seen at the edge,
    // then compare every output against it.
    task automatic step();
        bit run, tick, ovf;
        @(posedge core_clk);
        run  = enable && (trefi_cycles != 0);
        tick = 0;
        ovf  = 0;
        if (!m_running) begin
            if (run) begin
                m_running = 1;
                m_next    = m_cyc + int'(trefi_cycles);
            end
        end else if (!run) begin
            m_running = 0;
        end else if (m_cyc == m_next) begin
            tick   = 1;
            m_next = m_cyc + int'(trefi_cycles);
        end
        if (!run)                m_pend = 0;
        else if (tick && ref_ack) m_pend = (m_pend == 0) ? 1 : m_pend;
        else if (tick) begin
            if (m_pend < 8) m_pend++;
            else            ovf = 1;
        end else if (ref_ack && m_pend > 0) m_pend--;
        if (ovf)            m_err = 1;
        else if (clear_err) m_err = 0;
        m_cyc++;
        #1;
        chk("pending_cnt", int'(pending_cnt), m_pend);
        chk("ref_req", int'(ref_req), int'(m_pend != 0));
        chk("ref_urgent", int'(ref_urgent), int'(m_pend >= 6));
        chk("overflow_err", int'(overflow_err), int'(m_err));
    endtask

    // Single ack pulse, kept off tick edges so it retires exactly one entry
    task automatic lone_ack();
        int guard = 0;
        while (m_running && m_cyc == m_next && guard < 10) begin
            step();
            guard++;
        end
        ref_ack = 1'b1;
        step();
        ref_ack = 1'b0;
    endtask

    initial begin
        int guard;
        // reset state
        repeat (2) @(posedge core_clk);
        #3;
        chk("rst_pending", int'(pending_cnt), 0);
        chk("rst_req", int'(ref_req), 0);
        chk("rst_urgent", int'(ref_urgent), 0);
        chk("rst_err", int'(overflow_err), 0);
        @(negedge core_clk);
        core_arstn = 1'b1;
        @(posedge core_clk);
        #1;

        // first tick latency and urgency threshold, trefi=100, no acks
        trefi_cycles = 16'd100;
        enable = 1'b1;
        step();
        enable = 1'b1;
        repeat (99) step();
        chk("lit_pre_tick", int'(pending_cnt), 0);
        step();
        chk("lit_first_tick", int'(pending_cnt), 1);
        chk("lit_first_req", int'(ref_req), 1);
        repeat (499) step();
        chk("lit_pend5", int'(pending_cnt), 5);
        chk("lit_not_urgent", int'(ref_urgent), 0);
        step();
        chk("lit_pend6", int'(pending_cnt), 6);
        chk("lit_urgent", int'(ref_urgent), 1);

        // saturation and sticky overflow
        repeat (200) step();
        chk("lit_sat8", int'(pending_cnt), 8);
        chk("lit_no_ovf_yet", int'(overflow_err), 0);
        repeat (100) step();
        chk("lit_sat_hold", int'(pending_cnt), 8);
        chk("lit_ovf", int'(overflow_err), 1);
        clear_err = 1'b1;
        step();
        clear_err = 1'b0;
        chk("lit_ovf_clr", int'(overflow_err), 0);

        // tick and ack on the same edge cancel
        repeat (5) lone_ack();
        chk("lit_pend3", int'(pending_cnt), 3);
        guard = 0;
        while (m_cyc != m_next && guard < 200) begin
            step();
            guard++;
        end
        chk("tick_wait_timeout", int'(guard < 200), 1);
        ref_ack = 1'b1;
        step();
        ref_ack = 1'b0;
        chk("lit_tick_ack", int'(pending_cnt), 3);
        lone_ack();
        chk("lit_ack_to2", int'(pending_cnt), 2);

        // ack with nothing owed: no underflow
        lone_ack();
        lone_ack();
        lone_ack();
        chk("lit_no_underflow", int'(pending_cnt), 0);
        chk("lit_no_req", int'(ref_req), 0);

        // backlog discarded on disable, overflow retained; fresh interval on re-enable
        guard = 0;
        while (m_pend < 5 && guard < 1000) begin
            step();
            guard++;
        end
        chk("lit_pend5b", int'(pending_cnt), 5);
        enable = 1'b0;
        trefi_cycles = 16'd37;
        step();
        chk("lit_disable_clr", int'(pending_cnt), 0);
        enable = 1'b1;
        step();
        repeat (36) step();
        chk("lit_reen_pre", int'(pending_cnt), 0);
        step();
        chk("lit_reen_tick", int'(pending_cnt), 1);

        // async reset mid-count clears outputs without a clock edge
        repeat (20) step();
        #2;
        core_arstn = 1'b0;
        #1;
        chk("arst_pending", int'(pending_cnt), 0);
        chk("arst_req", int'(ref_req), 0);
        chk("arst_urgent", int'(ref_urgent), 0);
        chk("arst_err", int'(overflow_err), 0);
        m_running = 0;
        m_pend = 0;
        m_err = 0;
        enable = 1'b0;
        @(negedge core_clk);
        m_cyc++;
        core_arstn = 1'b1;

        // randomized traffic against the model
        enable = 1'b1;
        trefi_cycles = 16'd5;
        for (int i = 0; i < 6000; i++) begin
            int ack_div;
            if (i % 250 == 0) trefi_cycles = 16'($urandom_range(0, 12));
            if (trefi_cycles == 0 && i % 250 == 20) trefi_cycles = 16'd3;
            ack_div   = ((i / 500) % 2 == 0) ? 3 : 12;
            ref_ack   = ($urandom % ack_div) == 0;
            clear_err = ($urandom % 40) == 0;
            idle      = $urandom % 2;
            enable    = ($urandom % 400) != 0;
            step();
        end
        ref_ack = 1'b0;
        clear_err = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
